alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised successor to the datapath ALU: a full combinational integer ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the EX stage of the pipelined CPU.
- The combinational result serves arithmetic, logic, compare and shift instructions.
- The MD unit serves MULT/MULTU/DIV/DIVU/MTHI/MTLO and raises busy so the hazard unit can stall MFHI/MFLO and further MD instructions.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, power of two).
- MUL_LAT, 5, cycles busy is high for MULT/MULTU (>=1).
- DIV_LAT, 10, cycles busy is high for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in1  input  WIDTH  operand A (rs).
- in2  input  WIDTH  operand B (rt/imm).
- ALUop  input  4  combinational operation select.
- result  output  WIDTH  combinational ALU result.
- zero  output  1  1 when in1==in2.
- start  input  1  one-cycle request to launch an MD operation.
- md_op  input  3  MD operation, sampled when start=1.
- busy  output  1  MD unit occupied.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Combinational path, no state; SH = log2(WIDTH) low bits of in1.
  - ALUop 0 ADD, 1 SUB (both wrap, no overflow flag).
  - ALUop 2 OR, 3 AND, 4 XOR, 5 NOR.
  - ALUop 6 SLT (signed, result 1/0 zero-extended), 7 SLTU.
  - ALUop 8 SLL in2<<SH, 9 SRL, 10 SRA (arithmetic).
  - ALUop 11 LUI: in2 << WIDTH/2.
  - ALUop 12-15: result 0.
  - zero = (in1==in2) for every ALUop.
- md_op encoding: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, counter=0, latched operands=0. An operation in flight is discarded with no HI/LO update.
- FSM states: IDLE, RUN.
- IDLE, start=1, md_op in 1..4:
  - Latch in1, in2 and op at edge t; load counter with MUL_LAT or DIV_LAT; go RUN.
  - busy=1 from cycle t+1.
- IDLE, start=1, md_op 5/6: hi (resp. lo) <= in1 at edge t; no busy; stay IDLE.
- IDLE, start=1, md_op 0/7, or start=0: no effect.
- RUN: counter decrements each edge. On the edge where counter reaches 0, write HI/LO and return to IDLE. busy is high for exactly LAT cycles (t+1..t+LAT); new hi/lo are visible in the cycle busy first reads 0.
- hi/lo hold their old values throughout RUN; the result is computed from the latched operands only.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit must stall these.
- MULT: {hi,lo} = signed(A)*signed(B), 2*WIDTH bits. MULTU: unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend. DIVU: unsigned.
- DIV with A = most-negative and B = -1: lo = most-negative, hi = 0.
- Divide by zero (B==0, DIV or DIVU): full latency is still spent; hi and lo are left unchanged.
- Implementation choice is free (combinational product registered at the end, or iterative), provided the latency and result rules above hold exactly.

Test Plan:
- Combinational ops, WIDTH=32:
  - ALUop0, 7FFFFFFF + 1 -> 80000000; ALUop1, 0 - 1 -> FFFFFFFF.
  - ALUop6, in1=FFFFFFFF, in2=1 -> 1; ALUop7, same operands -> 0.
  - ALUop10, in1=4, in2=80000000 -> F8000000; ALUop11, in2=1234 -> 12340000.
  - zero=1 when in1=in2=5.
- MULT, in1=FFFFFFFE (-2), in2=3, start for one cycle:
  - busy high exactly 5 cycles.
  - then hi=FFFFFFFF, lo=FFFFFFFA.
  - MULTU with the same operands -> hi=00000002, lo=FFFFFFFA.
- DIV, in1=-7, in2=2 -> after 10 busy cycles, lo=FFFFFFFD, hi=FFFFFFFF.
  - DIVU 7/2 -> lo=3, hi=1.
  - DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- Divide by zero, hi=AAAA, lo=5555 beforehand: DIV x/0 -> busy 10 cycles, hi/lo unchanged.
- Busy interaction:
  - MTLO in1=1234 in IDLE -> lo=1234 next edge, busy stays 0.
  - During a MULT: start with MTHI or DIV is ignored, and the MULT result is correct.
- Reset asserted asynchronously in the 3rd busy cycle of a DIV -> busy, hi, lo = 0 immediately, with no late write-back after reset is released.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: combinational integer ALU plus a multi-cycle multiply/divide unit
// with HI/LO registers, for the EX stage of the pipelined CPU.
// The ALU path is purely combinational. The MD unit latches its operands at
// launch and keeps busy high for a fixed latency. It then writes HI/LO on the
// edge that ends the operation.
module alu_md #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic             start,
    input  logic [2:0]       md_op,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW     = $clog2(WIDTH);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0] sh;
    assign sh   = in1[SHW-1:0];
    assign zero = (in1 == in2);

    // Select the ALU result; shifts take their amount from the low bits of in1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        result = '0;
        case (ALUop)
            4'd0:    result = in1 + in2;
            4'd1:    result = in1 - in2;
            4'd2:    result = in1 | in2;
            4'd3:    result = in1 & in2;
            4'd4:    result = in1 ^ in2;
            4'd5:    result = ~(in1 | in2);
            4'd6:    result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'd7:    result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            4'd8:    result = in2 << sh;
            4'd9:    result = in2 >> sh;
            4'd10:   result = $signed(in2) >>> sh;
            4'd11:   result = in2 << (WIDTH / 2);
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply/divide unit state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    md_op_t           op_q, op_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    assign busy = (state_q == RUN);

    // ------------------------------------------------------------------
    // MD datapath: works only on the latched operands, so the operand bus
    // is free to change while the unit is running.
    // ------------------------------------------------------------------
    logic             sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe;
    logic [WIDTH-1:0] uq, ur, quo, rem;

    // Build the product and the sign-corrected quotient/remainder.
    always_comb begin
        sgn   = (op_q == MD_MULT) || (op_q == MD_DIV);
        a_ext = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        // The low 2*WIDTH bits of the extended product are the exact
        // two's-complement product for both the signed and unsigned cases.
        prod  = a_ext * b_ext;

        // Divide on magnitudes, then restore the signs: the quotient is
        // truncated toward zero and the remainder follows the dividend. The
        // most-negative / -1 case falls out naturally (magnitude 2^(W-1)
        // negates back to itself, remainder 0).
        a_neg    = sgn & a_q[WIDTH-1];
        b_neg    = sgn & b_q[WIDTH-1];
        a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
        div_zero = (b_q == '0);
        // Keep the divider well-defined on a zero divisor; its output is
        // discarded in that case anyway.
        b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        uq       = a_mag / b_safe;
        ur       = a_mag % b_safe;
        quo      = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        rem      = a_neg ? (~ur + 1'b1) : ur;
    end

    // Next-state logic: launch, move-to-HI/LO, countdown and write-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op_t'(md_op))
                        MD_MULT, MD_MULTU: begin
                            a_d     = in1;
                            b_d     = in2;
                            op_d    = md_op_t'(md_op);
                            cnt_d   = CW'(MUL_LAT);
                            state_d = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            a_d     = in1;
                            b_d     = in2;
                            op_d    = md_op_t'(md_op);
                            cnt_d   = CW'(DIV_LAT);
                            state_d = RUN;
                        end
                        MD_MTHI: hi_d = in1;
                        MD_MTLO: lo_d = in1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving while running are dropped; the hazard
                // unit is expected to stall them.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    case (op_q)
                        MD_MULT, MD_MULTU: {hi_d, lo_d} = prod;
                        MD_DIV, MD_DIVU: begin
                            if (!div_zero) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight without write-back.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every piece of MD state is reset, so an operation aborted by
        // reset leaves nothing behind that could write HI/LO later.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_NOP;
            hi      <= '0;
            lo      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all
            // registers update together from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Testbench for alu_md: directed vectors with hand-computed expectations.
// The driver pushes expected responses into a queue; an independent monitor
// pops and compares whenever the DUT presents a result.
module tb_alu_md;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum int {K_COMB, K_REGS, K_MD} kind_t;

    typedef struct {
        kind_t        kind;
        logic [W-1:0] res;
        logic         z;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] in1, in2;
    logic [3:0]   ALUop;
    logic [W-1:0] result;
    logic         zero;
    logic         start;
    logic [2:0]   md_op;
    logic         busy;
    logic [W-1:0] hi, lo;

    logic         chk;
    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;

    alu_md #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .in1    (in1),
        .in2    (in2),
        .ALUop  (ALUop),
        .result (result),
        .zero   (zero),
        .start  (start),
        .md_op  (md_op),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: busy falling marks an MD completion; chk marks a
    // combinational or register snapshot.
    // ------------------------------------------------------------------
    initial begin
        automatic bit prev_busy = 1'b0;
        automatic int busy_cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check("md_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("md_kind", W'(e.kind), W'(K_MD));
                    check("md_busy_cycles", W'(busy_cnt), W'(e.lat));
                    check("md_hi", hi, e.hi);
                    check("md_lo", lo, e.lo);
                end
            end
            if (busy !== 1'b1) busy_cnt = 0;
            if (chk === 1'b1) begin
                if (sb.size() == 0) begin
                    check("snap_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.kind == K_COMB) begin
                        check("alu_result", result, e.res);
                        check("alu_zero", W'(zero), W'(e.z));
                    end else begin
                        check("reg_kind", W'(e.kind), W'(K_REGS));
                        check("reg_busy", W'(busy), 32'd0);
                        check("reg_hi", hi, e.hi);
                        check("reg_lo", lo, e.lo);
                    end
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic comb(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input logic exp_z);
        exp_t e;
        @(posedge clk); #1;
        ALUop = op; in1 = a; in2 = b;
        e = '{kind: K_COMB, res: exp_r, z: exp_z, hi: '0, lo: '0, lat: 0};
        sb.push_back(e);
        chk = 1'b1;
        @(posedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic snap_regs(input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        exp_t e;
        e = '{kind: K_REGS, res: '0, z: 1'b0, hi: exp_hi, lo: exp_lo, lat: 0};
        sb.push_back(e);
        chk = 1'b1;
        @(posedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_drop", W'(busy), 32'd0);
    endtask

    task automatic md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int lat);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; md_op = op; in1 = a; in2 = b;
        e = '{kind: K_MD, res: '0, z: 1'b0, hi: exp_hi, lo: exp_lo, lat: lat};
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        wait_idle();
    endtask

    task automatic mt(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; in1 = a;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        snap_regs(exp_hi, exp_lo);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        reset = 1'b1;
        chk = 1'b0; start = 1'b0; md_op = 3'd0;
        in1 = '0; in2 = '0; ALUop = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        snap_regs(32'h0, 32'h0);

        // Combinational ALU
        comb(4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        comb(4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        comb(4'd2,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0);
        comb(4'd3,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0);
        comb(4'd4,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0);
        comb(4'd5,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0);
        comb(4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        comb(4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        comb(4'd8,  32'h00000024, 32'h00000001, 32'h00000010, 1'b0);
        comb(4'd9,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0);
        comb(4'd10, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0);
        comb(4'd11, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0);
        comb(4'd13, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0);
        comb(4'd0,  32'h00000005, 32'h00000005, 32'h0000000A, 1'b1);

        // Multiply / divide
        md(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        md(OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5);
        md(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        md(OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10);
        md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

        // MTLO in IDLE: immediate, no busy
        mt(OP_MTLO, 32'h00001234, 32'h00000000, 32'h00001234);

        // Starts issued during a MULT are ignored; operand bus changes too
        @(posedge clk); #1;
        start = 1'b1; md_op = OP_MULT; in1 = 32'd7; in2 = 32'd6;
        e = '{kind: K_MD, res: '0, z: 1'b0, hi: 32'h0, lo: 32'h0000002A, lat: 5};
        sb.push_back(e);
        @(posedge clk); #1;
        md_op = OP_MTHI; in1 = 32'h0000DEAD;
        @(posedge clk); #1;
        md_op = OP_DIV; in1 = 32'd100; in2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        wait_idle();

        // Divide by zero leaves HI/LO untouched
        mt(OP_MTHI, 32'h0000AAAA, 32'h0000AAAA, 32'h0000002A);
        mt(OP_MTLO, 32'h00005555, 32'h0000AAAA, 32'h00005555);
        md(OP_DIV, 32'h00000009, 32'h00000000, 32'h0000AAAA, 32'h00005555, 10);

        // Asynchronous reset in the third busy cycle of a DIV
        @(posedge clk); #1;
        start = 1'b1; md_op = OP_DIV; in1 = 32'd100; in2 = 32'd7;
        e = '{kind: K_MD, res: '0, z: 1'b0, hi: 32'h0, lo: 32'h0, lat: 2};
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        snap_regs(32'h0, 32'h0);

        repeat (3) @(posedge clk);
        check("queue_drained", W'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
